// File: rtl/mult_div_unit.sv
// Iterative 32-bit MIPS-style multiply/divide unit with architectural HI/LO.
// Shift-add multiply and restoring divide, one bit per cycle, sign fixup in a final cycle.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] busA,
  input  logic [31:0] busB,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  localparam int unsigned W    = 32;
  localparam int unsigned CW   = 5;
  localparam int unsigned LAST = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]  cnt;
  logic           is_div;
  logic           neg_q;
  logic           neg_r;
  logic [W-1:0]   opnd;
  logic [W-1:0]   a_orig;
  logic [2*W-1:0] acc;

  logic           neg_a_c, neg_b_c;
  logic [W-1:0]   mag_a_c, mag_b_c;
  logic [W:0]     mul_sum_c;
  logic [2*W-1:0] mul_step_c;
  logic           div_ge_c;
  logic [W-1:0]   div_rem_c;
  logic [2*W-1:0] div_step_c;
  logic [2*W-1:0] prod_c;
  logic [W-1:0]   quot_c;
  logic [W-1:0]   rem_c;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (cnt == CW'(LAST)) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand magnitudes for signed ops (op[0] selects signed)
  always_comb begin
    neg_a_c = op[0] & busA[W-1];
    neg_b_c = op[0] & busB[W-1];
    mag_a_c = neg_a_c ? W'(-busA) : busA;
    mag_b_c = neg_b_c ? W'(-busB) : busB;
  end

  // One iteration of multiply (acc = {partial, multiplier}) and divide (acc = {rem, dividend})
  always_comb begin
    mul_sum_c  = {1'b0, acc[2*W-1:W]} + {1'b0, opnd};
    mul_step_c = acc[0] ? {mul_sum_c, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};
    div_ge_c   = acc[2*W-1:W-1] >= {1'b0, opnd};
    div_rem_c  = W'(acc[2*W-1:W-1] - {1'b0, opnd});
    div_step_c = div_ge_c ? {div_rem_c, acc[W-2:0], 1'b1} : {acc[2*W-2:0], 1'b0};
  end

  // Sign fixup applied in FIX
  always_comb begin
    prod_c = neg_q ? (2*W)'(-acc) : acc;
    quot_c = neg_q ? W'(-acc[W-1:0]) : acc[W-1:0];
    rem_c  = neg_r ? W'(-acc[2*W-1:W]) : acc[2*W-1:W];
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      opnd        <= '0;
      a_orig      <= '0;
      acc         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt         <= '0;
            is_div      <= op[1];
            neg_q       <= neg_a_c ^ neg_b_c;
            neg_r       <= neg_a_c;
            a_orig      <= busA;
            div_by_zero <= op[1] && (busB == '0);
            // Multiply keeps |a| as adder operand; divide keeps |b| as divisor
            opnd        <= op[1] ? mag_b_c : mag_a_c;
            acc         <= op[1] ? {{W{1'b0}}, mag_a_c} : {{W{1'b0}}, mag_b_c};
          end else begin
            if (mthi) hi <= busA;
            if (mtlo) lo <= busA;
          end
        end
        RUN: begin
          acc <= is_div ? div_step_c : mul_step_c;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          done <= 1'b1;
          if (!is_div) begin
            hi <= prod_c[2*W-1:W];
            lo <= prod_c[W-1:0];
          end else if (div_by_zero) begin
            hi <= a_orig;
            lo <= '1;
          end else begin
            hi <= rem_c;
            lo <= quot_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random ops against
// a plain-arithmetic HI/LO reference model.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic [31:0] busA;
  logic [31:0] busB;
  logic        start;
  logic [1:0]  op;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int vectors     = 0;
  int miscompares = 0;

  mult_div_unit dut (
    .clk         (clk),
    .reset       (reset),
    .busA        (busA),
    .busB        (busB),
    .start       (start),
    .op          (op),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: returns {HI, LO}
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    if (o[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    if (!o[1]) begin
      p = 64'(sa * sb);
      return p;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op; optionally glitch start/mthi/mtlo mid-run, or raise mthi/mtlo with start
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit glitch, input bit with_mt, input string tag);
    logic [63:0] exp;
    logic [31:0] prev_hi, prev_lo;
    int n, busy_cnt;
    bit got;
    exp     = model(o, a, b);
    prev_hi = hi;
    prev_lo = lo;
    start = 1'b1; op = o; busA = a; busB = b;
    mthi = with_mt; mtlo = with_mt;
    tick();
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    chk({tag, " busy_after_start"}, 64'(busy), 64'd1);
    chk({tag, " dbz_after_start"}, 64'(div_by_zero), 64'(o[1] && (b == 32'd0)));
    chk({tag, " hilo_held"}, {hi, lo}, {prev_hi, prev_lo});
    busy_cnt = 1;
    n = 0;
    got = 0;
    while (!got && n < 60) begin
      busA = $urandom;
      busB = $urandom;
      if (glitch && n == 4) begin
        start = 1'b1; op = 2'b10; mthi = 1'b1; mtlo = 1'b1;
      end else begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      end
      tick();
      n++;
      if (done) got = 1;
      else if (busy) busy_cnt++;
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    chk({tag, " done_seen"}, 64'(got), 64'd1);
    chk({tag, " latency"}, 64'(n), 64'd33);
    chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
    chk({tag, " busy_in_done"}, 64'(busy), 64'd0);
    chk({tag, " hi"}, 64'(hi), 64'(exp[63:32]));
    chk({tag, " lo"}, 64'(lo), 64'(exp[31:0]));
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    bit seen;

    reset = 1'b1; start = 1'b0; op = 2'b00; mthi = 1'b0; mtlo = 1'b0;
    busA = 32'd0; busB = 32'd0;
    tick();
    tick();
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset hilo", {hi, lo}, 64'd0);
    chk("reset dbz", 64'(div_by_zero), 64'd0);
    reset = 1'b0;

    // mthi / mtlo in IDLE
    mthi = 1'b1; busA = 32'h1234_5678;
    tick();
    mthi = 1'b0;
    chk("mthi hi", 64'(hi), 64'h1234_5678);
    chk("mthi lo_kept", 64'(lo), 64'd0);
    mtlo = 1'b1; busA = 32'h9ABC_DEF0;
    tick();
    mtlo = 1'b0;
    chk("mtlo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
    mthi = 1'b1; mtlo = 1'b1; busA = 32'h55AA_33CC;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthi_mtlo both", {hi, lo}, 64'h55AA_33CC_55AA_33CC);

    // Directed operations
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "multu max");
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 0, 0, "mult neg");
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0, "div neg");
    run_op(2'b10, 32'd100, 32'd0, 0, 0, "divu by0");
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div ovf");
    chk("div ovf dbz", 64'(div_by_zero), 64'd0);
    run_op(2'b00, 32'd6, 32'd7, 1, 0, "multu glitch");
    run_op(2'b10, 32'd42, 32'd5, 0, 0, "divu done_cycle");
    tick();
    chk("done one cycle", 64'(done), 64'd0);
    run_op(2'b01, 32'd3, 32'd5, 0, 1, "mult start_over_mt");

    // Reset mid-operation
    start = 1'b1; op = 2'b01; busA = 32'd1234; busB = 32'hFFFF_0001;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset busy", 64'(busy), 64'd0);
    chk("midreset done", 64'(done), 64'd0);
    chk("midreset hilo", {hi, lo}, 64'd0);
    seen = 0;
    repeat (40) begin
      tick();
      if (done) seen = 1;
    end
    chk("midreset no_done", 64'(seen), 64'd0);

    // Random ops
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, 0, (i % 5) == 0, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
